// File: rtl/plot_pkg.sv
// rtl/plot_pkg.sv - shared mode/state encodings and screen defaults for the rectangle plotter
package plot_pkg;

    typedef enum logic [1:0] {
        MODE_FILL    = 2'b00,
        MODE_OUTLINE = 2'b01,
        MODE_CLEAR   = 2'b10
    } mode_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_DRAW = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    localparam int DEF_X_SCREEN_PIXELS = 160;
    localparam int DEF_Y_SCREEN_PIXELS = 120;

endpackage

// File: rtl/raster_counter.sv
// rtl/raster_counter.sv - dx/dy raster-order scanner over a w x h box
module raster_counter #(
    parameter int X_WIDTH = 8,
    parameter int Y_WIDTH = 7
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               enable,
    input  logic [X_WIDTH-1:0] w,
    input  logic [Y_WIDTH-1:0] h,
    output logic [X_WIDTH-1:0] dx,
    output logic [Y_WIDTH-1:0] dy,
    output logic               last
);

    logic [X_WIDTH-1:0] dx_q, dx_d;
    logic [Y_WIDTH-1:0] dy_q, dy_d;
    logic               row_end;

    // w and h are never zero while enabled, so w-1/h-1 do not underflow in use
    assign row_end = (dx_q == w - X_WIDTH'(1));
    assign last    = row_end && (dy_q == h - Y_WIDTH'(1));
    assign dx      = dx_q;
    assign dy      = dy_q;

    // next counter values: clear wins, otherwise dx runs fastest and carries into dy
    always_comb begin
        dx_d = dx_q;
        dy_d = dy_q;
        if (clear) begin
            dx_d = '0;
            dy_d = '0;
        end else if (enable) begin
            if (row_end) begin
                dx_d = '0;
                dy_d = dy_q + Y_WIDTH'(1);
            end else begin
                dx_d = dx_q + X_WIDTH'(1);
            end
        end
    end

    // counter registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dx_q <= '0;
            dy_q <= '0;
        end else begin
            dx_q <= dx_d;
            dy_q <= dy_d;
        end
    end

endmodule

// File: rtl/rect_plotter.sv
// rtl/rect_plotter.sv - command FSM, clipping and outline selection for the VGA pixel path
module rect_plotter
    import plot_pkg::*;
#(
    parameter int X_SCREEN_PIXELS = DEF_X_SCREEN_PIXELS,
    parameter int Y_SCREEN_PIXELS = DEF_Y_SCREEN_PIXELS,
    parameter int X_WIDTH         = 8,
    parameter int Y_WIDTH         = 7,
    parameter int COLOUR_WIDTH    = 3
) (
    input  logic                    iClock,
    input  logic                    iReset,
    input  logic                    iValid,
    output logic                    oReady,
    input  logic [1:0]              iMode,
    input  logic [X_WIDTH-1:0]      iX,
    input  logic [Y_WIDTH-1:0]      iY,
    input  logic [X_WIDTH-1:0]      iW,
    input  logic [Y_WIDTH-1:0]      iH,
    input  logic [COLOUR_WIDTH-1:0] iColour,
    input  logic                    iAbort,
    output logic [X_WIDTH-1:0]      oX,
    output logic [Y_WIDTH-1:0]      oY,
    output logic [COLOUR_WIDTH-1:0] oColour,
    output logic                    oPlot,
    output logic                    oDone,
    output logic                    oBusy
);

    localparam logic [X_WIDTH:0] X_LIM = (X_WIDTH+1)'(X_SCREEN_PIXELS);
    localparam logic [Y_WIDTH:0] Y_LIM = (Y_WIDTH+1)'(Y_SCREEN_PIXELS);

    state_t                  state_q, state_d;
    mode_t                   mode_q, mode_d;
    logic [X_WIDTH-1:0]      x0_q, x0_d, w_q, w_d;
    logic [Y_WIDTH-1:0]      y0_q, y0_d, h_q, h_d;
    logic [COLOUR_WIDTH-1:0] colour_q, colour_d;

    logic                    cnt_clear, cnt_enable, cnt_last;
    logic [X_WIDTH-1:0]      dx;
    logic [Y_WIDTH-1:0]      dy;

    logic [X_WIDTH:0]        sum_x;
    logic [Y_WIDTH:0]        sum_y;
    logic                    on_screen, on_border, selected;

    // counters hold zero whenever the next state leaves DRAW, so DONE/IDLE see cleared counters
    assign cnt_enable = (state_q == ST_DRAW);
    assign cnt_clear  = (state_d != ST_DRAW);

    raster_counter #(
        .X_WIDTH(X_WIDTH),
        .Y_WIDTH(Y_WIDTH)
    ) u_raster (
        .clk   (iClock),
        .rst   (iReset),
        .clear (cnt_clear),
        .enable(cnt_enable),
        .w     (w_q),
        .h     (h_q),
        .dx    (dx),
        .dy    (dy),
        .last  (cnt_last)
    );

    // next-state and command latch; mode 11 folds into FILL, CLEAR substitutes the whole screen
    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        x0_d     = x0_q;
        y0_d     = y0_q;
        w_d      = w_q;
        h_d      = h_q;
        colour_d = colour_q;
        case (state_q)
            ST_IDLE: begin
                if (iValid) begin
                    if (iMode == MODE_CLEAR) begin
                        mode_d   = MODE_CLEAR;
                        x0_d     = '0;
                        y0_d     = '0;
                        w_d      = X_WIDTH'(X_SCREEN_PIXELS);
                        h_d      = Y_WIDTH'(Y_SCREEN_PIXELS);
                        colour_d = '0;
                    end else begin
                        mode_d   = (iMode == MODE_OUTLINE) ? MODE_OUTLINE : MODE_FILL;
                        x0_d     = iX;
                        y0_d     = iY;
                        w_d      = iW;
                        h_d      = iH;
                        colour_d = iColour;
                    end
                    state_d = ((w_d == '0) || (h_d == '0)) ? ST_DONE : ST_DRAW;
                end
            end
            ST_DRAW: begin
                if (iAbort || cnt_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and command registers
    always_ff @(posedge iClock or posedge iReset) begin
        if (iReset) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_FILL;
            x0_q     <= '0;
            y0_q     <= '0;
            w_q      <= '0;
            h_q      <= '0;
            colour_q <= '0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            x0_q     <= x0_d;
            y0_q     <= y0_d;
            w_q      <= w_d;
            h_q      <= h_d;
            colour_q <= colour_d;
        end
    end

    // pixel decode from registered state only: widened sums detect clipping past the screen edge
    always_comb begin
        sum_x     = {1'b0, x0_q} + {1'b0, dx};
        sum_y     = {1'b0, y0_q} + {1'b0, dy};
        on_screen = (sum_x < X_LIM) && (sum_y < Y_LIM);
        on_border = (dx == '0) || (dx == w_q - X_WIDTH'(1)) ||
                    (dy == '0) || (dy == h_q - Y_WIDTH'(1));
        selected  = (mode_q != MODE_OUTLINE) || on_border;
    end

    assign oX      = sum_x[X_WIDTH-1:0];
    assign oY      = sum_y[Y_WIDTH-1:0];
    assign oColour = colour_q;
    assign oPlot   = (state_q == ST_DRAW) && on_screen && selected;
    assign oDone   = (state_q == ST_DONE);
    assign oReady  = (state_q == ST_IDLE);
    assign oBusy   = !oReady;

endmodule

// File: tb/tb_rect_plotter.sv
// tb/tb_rect_plotter.sv - directed self-checking bench for rect_plotter
module tb_rect_plotter;

    logic       iClock = 1'b0;
    logic       iReset = 1'b1;
    logic       iValid = 1'b0;
    logic       oReady;
    logic [1:0] iMode = 2'b00;
    logic [7:0] iX = '0;
    logic [6:0] iY = '0;
    logic [7:0] iW = '0;
    logic [6:0] iH = '0;
    logic [2:0] iColour = '0;
    logic       iAbort = 1'b0;
    logic [7:0] oX;
    logic [6:0] oY;
    logic [2:0] oColour;
    logic       oPlot;
    logic       oDone;
    logic       oBusy;

    int checks   = 0;
    int failures = 0;

    rect_plotter dut (
        .iClock (iClock),
        .iReset (iReset),
        .iValid (iValid),
        .oReady (oReady),
        .iMode  (iMode),
        .iX     (iX),
        .iY     (iY),
        .iW     (iW),
        .iH     (iH),
        .iColour(iColour),
        .iAbort (iAbort),
        .oX     (oX),
        .oY     (oY),
        .oColour(oColour),
        .oPlot  (oPlot),
        .oDone  (oDone),
        .oBusy  (oBusy)
    );

    always #5 iClock = ~iClock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Issue one command and follow it cycle by cycle until oDone.
    // abort_cyc: scan cycle (1-based) in which iAbort is held, 0 for none.
    // hold_valid: keep iValid high (with other fields) during the whole command.
    task automatic run_cmd(input string name, input logic [1:0] m, input int x, input int y,
                           input int w, input int h, input int c, input int abort_cyc,
                           input bit hold_valid, input int exp_plots, input int exp_scan);
        int mx, my, mw, mh, mc;
        int scan, plots, done_cyc;
        int dx, dy;
        bit exp_plot;
        mx = x; my = y; mw = w; mh = h; mc = c;
        if (m == 2'b10) begin
            mx = 0; my = 0; mw = 160; mh = 120; mc = 0;
        end
        @(negedge iClock);
        check({name, "_ready"}, oReady, 1);
        iValid = 1'b1; iMode = m;
        iX = 8'(x); iY = 7'(y); iW = 8'(w); iH = 7'(h); iColour = 3'(c);
        @(posedge iClock);
        #1;
        if (hold_valid) begin
            iX = 8'd3; iY = 7'd3; iW = 8'd9; iH = 7'd9; iColour = 3'd7;
        end else begin
            iValid = 1'b0;
        end
        scan = 0; plots = 0; done_cyc = -1;
        for (int cyc = 1; cyc <= 20000; cyc++) begin
            iAbort = (abort_cyc != 0) && (cyc == abort_cyc);
            @(negedge iClock);
            if (oDone) begin
                done_cyc = cyc;
                break;
            end
            if (cyc == 1) check({name, "_busy"}, oBusy, 1);
            dx = scan % mw;
            dy = scan / mw;
            exp_plot = ((mx + dx) < 160) && ((my + dy) < 120) &&
                       ((m == 2'b00) || (m == 2'b10) || (m == 2'b11) ||
                        (dx == 0) || (dx == mw - 1) || (dy == 0) || (dy == mh - 1));
            check({name, "_plot"}, oPlot, exp_plot);
            if (oPlot) begin
                plots++;
                check({name, "_x"}, oX, mx + dx);
                check({name, "_y"}, oY, my + dy);
                check({name, "_colour"}, oColour, mc);
            end
            scan++;
            @(posedge iClock);
            #1;
        end
        iAbort = 1'b0;
        iValid = 1'b0;
        check({name, "_plots"}, plots, exp_plots);
        check({name, "_scan"}, scan, exp_scan);
        check({name, "_done_cycle"}, done_cyc, exp_scan + 1);
        @(negedge iClock);
        check({name, "_ready_after"}, oReady, 1);
        check({name, "_done_pulse"}, oDone, 0);
    endtask

    initial begin
        #2;
        check("rst_x", oX, 0);
        check("rst_y", oY, 0);
        check("rst_colour", oColour, 0);
        check("rst_plot", oPlot, 0);
        check("rst_done", oDone, 0);
        check("rst_busy", oBusy, 0);
        check("rst_ready", oReady, 1);
        @(negedge iClock);
        iReset = 1'b0;
        repeat (2) @(posedge iClock);
        #1;

        run_cmd("fill",    2'b00, 10, 20, 4, 4, 5, 0, 1'b0, 16, 16);
        run_cmd("outline", 2'b01, 0, 0, 5, 3, 6, 0, 1'b0, 12, 15);
        run_cmd("clip",    2'b00, 158, 118, 4, 4, 2, 0, 1'b0, 4, 16);
        run_cmd("mode3",   2'b11, 30, 40, 3, 2, 1, 0, 1'b0, 6, 6);
        run_cmd("zero",    2'b00, 5, 5, 0, 7, 3, 0, 1'b0, 0, 0);
        run_cmd("ignore",  2'b00, 50, 60, 2, 2, 4, 0, 1'b1, 4, 4);
        run_cmd("abort",   2'b00, 10, 20, 4, 4, 5, 6, 1'b0, 6, 6);
        run_cmd("clear",   2'b10, 77, 33, 9, 9, 7, 0, 1'b0, 19200, 19200);

        // async reset in the middle of a draw
        @(negedge iClock);
        iValid = 1'b1; iMode = 2'b00; iX = 8'd10; iY = 7'd20; iW = 8'd4; iH = 7'd4; iColour = 3'd5;
        @(posedge iClock);
        #1 iValid = 1'b0;
        @(negedge iClock);
        check("mid_plot_before", oPlot, 1);
        @(posedge iClock);
        #2 iReset = 1'b1;
        #1;
        check("arst_plot", oPlot, 0);
        check("arst_x", oX, 0);
        check("arst_y", oY, 0);
        check("arst_colour", oColour, 0);
        check("arst_done", oDone, 0);
        check("arst_busy", oBusy, 0);
        check("arst_ready", oReady, 1);
        @(negedge iClock);
        iReset = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge iClock);
            check("arst_no_done", oDone, 0);
            check("arst_no_plot", oPlot, 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
